// File: rtl/cond_pkg.sv
// ----------------------------------------------------------------------------
// cond_pkg
//   Shared types and constants for the EX-stage conditional branch unit.
//   - br_type_t : branch kind carried by the EX op
//   - cond_t    : 4-bit B.cond condition codes, EQ..NV
//   - state_t   : two-state resolve FSM encoding
//   - *_IDX     : bit positions inside the {N,Z,C,V} flag vector
// ----------------------------------------------------------------------------
package cond_pkg;

    typedef enum logic [1:0] {
        BR_NONE  = 2'd0,
        BR_BCOND = 2'd1,
        BR_CBZ   = 2'd2,
        BR_CBNZ  = 2'd3
    } br_type_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_HS = 4'd2,
        COND_LO = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RESOLVE = 1'b1
    } state_t;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

endpackage

// File: rtl/cond_eval.sv
// ----------------------------------------------------------------------------
// cond_eval
//   Purely combinational B.cond evaluator.
//   Ports:
//     cond  [3:0] in  : condition code (cond_t encoding)
//     flags [3:0] in  : effective flags {N,Z,C,V}
//     taken       out : condition holds for the given flags
// ----------------------------------------------------------------------------
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[N_IDX];
    assign z = flags[Z_IDX];
    assign c = flags[C_IDX];
    assign v = flags[V_IDX];

    always_comb begin
        taken = 1'b0;
        case (cond_t'(cond))
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_HS: taken = c;
            COND_LO: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c & !z;
            COND_LS: taken = !c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z & (n == v);
            COND_LE: taken = z | (n != v);
            // AL and NV both mean "always" in this ISA.
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_unit.sv
// ----------------------------------------------------------------------------
// cond_branch_unit
//   EX-stage NZCV flag register plus B.cond / CBZ / CBNZ resolver. The
//   decision is registered and shown to fetch/PC-select one cycle after the
//   branch is accepted.
//
//   Handshake: an EX op is consumed ("accepted") in a cycle where
//   op_valid=1, stall=0 and flush=0. stall acts as a not-ready back-pressure
//   from the pipeline; flush kills the op regardless of stall. Only accepted
//   ops may write flags or start a decision. br_resolved is a one-cycle
//   valid pulse with no ready: downstream must take it in that cycle.
//
//   Ports:
//     clk, reset (active-low async)
//     alu_zero/alu_neg/alu_carry/alu_ovf : live ALU flags
//     set_flags   : op writes NZCV
//     op_valid    : EX slot holds a real instruction
//     br_type[1:0]: NONE/BCOND/CBZ/CBNZ
//     cond[3:0]   : B.cond code
//     reg_zero    : register operand is zero (CBZ/CBNZ)
//     stall/flush : pipeline control
//     nzcv[3:0]   : stored flags {N,Z,C,V}
//     br_resolved : decision presented this cycle
//     br_taken    : decision value, valid with br_resolved
// ----------------------------------------------------------------------------
module cond_branch_unit
    import cond_pkg::*;
#(
    parameter bit         FORWARD_EN = 1'b1,
    parameter logic [3:0] RESET_NZCV = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_zero,
    input  logic       alu_neg,
    input  logic       alu_carry,
    input  logic       alu_ovf,
    input  logic       set_flags,
    input  logic       op_valid,
    input  logic [1:0] br_type,
    input  logic [3:0] cond,
    input  logic       reg_zero,
    input  logic       stall,
    input  logic       flush,
    output logic [3:0] nzcv,
    output logic       br_resolved,
    output logic       br_taken
);

    state_t     state;
    state_t     state_next;
    logic       taken_q;
    logic       taken_next;
    logic       accept;
    logic [3:0] live_flags;
    logic [3:0] eff_flags;
    logic       cond_taken;
    logic       branch_taken;

    assign accept     = op_valid & !stall & !flush;
    assign live_flags = {alu_neg, alu_zero, alu_carry, alu_ovf};

    // A B.cond paired with a flag write in the same slot sees the new flags
    // when forwarding is enabled; otherwise it reads the stored register.
    assign eff_flags = (FORWARD_EN && set_flags && op_valid) ? live_flags : nzcv;

    cond_eval u_cond_eval (
        .cond  (cond),
        .flags (eff_flags),
        .taken (cond_taken)
    );

    always_comb begin
        branch_taken = 1'b0;
        case (br_type_t'(br_type))
            BR_BCOND: branch_taken = cond_taken;
            BR_CBZ:   branch_taken = reg_zero;
            BR_CBNZ:  branch_taken = !reg_zero;
            default:  branch_taken = 1'b0;
        endcase
    end

    // Flag register: only accepted flag-setting ops write it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nzcv <= RESET_NZCV;
        end else if (accept && set_flags) begin
            nzcv <= live_flags;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            taken_q <= 1'b0;
        end else begin
            state   <= state_next;
            taken_q <= taken_next;
        end
    end

    // RESOLVE lasts exactly one cycle unless another branch is accepted in
    // that same cycle, so both states share the same transition rule.
    always_comb begin
        state_next = ST_IDLE;
        taken_next = 1'b0;
        case (state)
            ST_IDLE, ST_RESOLVE: begin
                if (accept && (br_type_t'(br_type) != BR_NONE)) begin
                    state_next = ST_RESOLVE;
                    taken_next = branch_taken;
                end
            end
            default: begin
                state_next = ST_IDLE;
                taken_next = 1'b0;
            end
        endcase
    end

    assign br_resolved = (state == ST_RESOLVE);
    assign br_taken    = (state == ST_RESOLVE) & taken_q;

endmodule

// File: tb/tb_cond_branch_unit.sv
// ----------------------------------------------------------------------------
// tb_cond_branch_unit
//   Directed bench for cond_branch_unit. Two instances share all inputs:
//   dut_fwd (FORWARD_EN=1) and dut_nofwd (FORWARD_EN=0).
// ----------------------------------------------------------------------------
module tb_cond_branch_unit;

    logic       clk;
    logic       reset;
    logic       alu_zero;
    logic       alu_neg;
    logic       alu_carry;
    logic       alu_ovf;
    logic       set_flags;
    logic       op_valid;
    logic [1:0] br_type;
    logic [3:0] cond;
    logic       reg_zero;
    logic       stall;
    logic       flush;

    logic [3:0] nzcv_f;
    logic       res_f;
    logic       tkn_f;
    logic [3:0] nzcv_n;
    logic       res_n;
    logic       tkn_n;

    int checks;
    int errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    cond_branch_unit #(.FORWARD_EN(1'b1), .RESET_NZCV(4'b0000)) dut_fwd (
        .clk(clk), .reset(reset),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .set_flags(set_flags), .op_valid(op_valid), .br_type(br_type), .cond(cond),
        .reg_zero(reg_zero), .stall(stall), .flush(flush),
        .nzcv(nzcv_f), .br_resolved(res_f), .br_taken(tkn_f)
    );

    cond_branch_unit #(.FORWARD_EN(1'b0), .RESET_NZCV(4'b0000)) dut_nofwd (
        .clk(clk), .reset(reset),
        .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
        .set_flags(set_flags), .op_valid(op_valid), .br_type(br_type), .cond(cond),
        .reg_zero(reg_zero), .stall(stall), .flush(flush),
        .nzcv(nzcv_n), .br_resolved(res_n), .br_taken(tkn_n)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        alu_zero  = 1'b0;
        alu_neg   = 1'b0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        set_flags = 1'b0;
        op_valid  = 1'b0;
        br_type   = 2'd0;
        cond      = 4'd0;
        reg_zero  = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_subs(input logic [3:0] f);
        op_valid  = 1'b1;
        set_flags = 1'b1;
        br_type   = 2'd0;
        alu_neg   = f[3];
        alu_zero  = f[2];
        alu_carry = f[1];
        alu_ovf   = f[0];
    endtask

    task automatic drive_branch(input logic [1:0] bt, input logic [3:0] c, input logic rz);
        op_valid = 1'b1;
        br_type  = bt;
        cond     = c;
        reg_zero = rz;
    endtask

    task automatic write_flags(input logic [3:0] f);
        idle_inputs();
        drive_subs(f);
        tick();
        idle_inputs();
    endtask

    // Sweep all 16 codes against stored flags; table bit i = expected for code i.
    task automatic sweep(input logic [3:0] f, input logic [15:0] tab);
        logic [15:0] t;
        t = tab;
        write_flags(f);
        check("sweep_nzcv", {12'd0, nzcv_f}, {12'd0, f});
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            drive_branch(2'd1, i[3:0], 1'b0);
            tick();
            idle_inputs();
            check($sformatf("sweep_%0h_c%0d_fwd", f, i), {14'd0, res_f, tkn_f}, {14'd0, 1'b1, t[i]});
            check($sformatf("sweep_%0h_c%0d_nofwd", f, i), {15'd0, tkn_n}, {15'd0, t[i]});
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        reset = 1'b0;
        #3;
        check("in_reset_nzcv", {12'd0, nzcv_f}, 16'h0000);
        check("in_reset_res", {15'd0, res_f}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle_res_%0d", i), {15'd0, res_f}, 16'h0000);
            check($sformatf("idle_nzcv_%0d", i), {12'd0, nzcv_f}, 16'h0000);
        end

        // SUBS: Z=1, C=1
        write_flags(4'b0110);
        check("subs_nzcv_fwd", {12'd0, nzcv_f}, 16'h0006);
        check("subs_nzcv_nofwd", {12'd0, nzcv_n}, 16'h0006);

        // B.cond EQ -> taken, one cycle later
        drive_branch(2'd1, 4'd0, 1'b0);
        tick();
        idle_inputs();
        check("beq_res_taken", {14'd0, res_f, tkn_f}, 16'h0003);
        tick();
        check("beq_res_drop", {15'd0, res_f}, 16'h0000);

        // B.cond LO -> not taken
        drive_branch(2'd1, 4'd3, 1'b0);
        tick();
        idle_inputs();
        check("blo_res_taken", {14'd0, res_f, tkn_f}, 16'h0002);

        // Forwarding: stored 0000, same-cycle SUBS N=1 V=0 with B.cond LT
        write_flags(4'b0000);
        drive_subs(4'b1000);
        drive_branch(2'd1, 4'd11, 1'b0);
        tick();
        idle_inputs();
        check("fwd_lt_on", {14'd0, res_f, tkn_f}, 16'h0003);
        check("fwd_lt_off", {14'd0, res_n, tkn_n}, 16'h0002);
        check("fwd_nzcv", {12'd0, nzcv_f}, 16'h0008);
        check("fwd_nzcv_nofwd", {12'd0, nzcv_n}, 16'h0008);

        // CBZ / CBNZ with ALU flags toggling but no flag write
        alu_zero  = 1'b1;
        alu_carry = 1'b1;
        drive_branch(2'd2, 4'd0, 1'b1);
        tick();
        idle_inputs();
        check("cbz_taken", {14'd0, res_f, tkn_f}, 16'h0003);
        check("cbz_nzcv", {12'd0, nzcv_f}, 16'h0008);
        alu_ovf = 1'b1;
        drive_branch(2'd3, 4'd0, 1'b1);
        tick();
        idle_inputs();
        check("cbnz_taken", {14'd0, res_f, tkn_f}, 16'h0002);
        check("cbnz_nzcv", {12'd0, nzcv_f}, 16'h0008);

        // Flush: BCOND AL killed; SUBS killed
        drive_branch(2'd1, 4'd14, 1'b0);
        flush = 1'b1;
        tick();
        idle_inputs();
        check("flush_bal_res", {15'd0, res_f}, 16'h0000);
        drive_subs(4'b0110);
        flush = 1'b1;
        tick();
        idle_inputs();
        check("flush_subs_nzcv", {12'd0, nzcv_f}, 16'h0008);

        // Flush while RESOLVE is being presented, flush also asserts stall
        drive_branch(2'd1, 4'd14, 1'b0);
        tick();
        check("pre_flush_res", {15'd0, res_f}, 16'h0001);
        drive_branch(2'd1, 4'd14, 1'b0);
        flush = 1'b1;
        stall = 1'b1;
        tick();
        idle_inputs();
        check("flush_in_resolve", {14'd0, res_f, tkn_f}, 16'h0000);

        // Stall holds flags, release writes them
        drive_subs(4'b0110);
        stall = 1'b1;
        tick();
        check("stall_nzcv_hold", {12'd0, nzcv_f}, 16'h0008);
        stall = 1'b0;
        tick();
        idle_inputs();
        check("stall_release_nzcv", {12'd0, nzcv_f}, 16'h0006);

        // Stall while RESOLVE shown: pulse completes once, no re-issue
        drive_branch(2'd1, 4'd0, 1'b0);
        tick();
        stall = 1'b1;
        check("stall_resolve_res", {14'd0, res_f, tkn_f}, 16'h0003);
        tick();
        idle_inputs();
        check("stall_no_reissue", {15'd0, res_f}, 16'h0000);

        // Back-to-back EQ then NE with Z=1
        drive_branch(2'd1, 4'd0, 1'b0);
        tick();
        check("b2b_first", {14'd0, res_f, tkn_f}, 16'h0003);
        drive_branch(2'd1, 4'd1, 1'b0);
        tick();
        idle_inputs();
        check("b2b_second", {14'd0, res_f, tkn_f}, 16'h0002);
        tick();
        check("b2b_end", {15'd0, res_f}, 16'h0000);

        // Condition table sweeps
        sweep(4'b0110, 16'hE6A5);
        sweep(4'b1001, 16'hD65A);
        sweep(4'b1010, 16'hE996);

        // Asynchronous reset in the middle of RESOLVE
        drive_branch(2'd1, 4'd14, 1'b0);
        tick();
        idle_inputs();
        check("pre_reset_res", {14'd0, res_f, tkn_f}, 16'h0003);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_out", {14'd0, res_f, tkn_f}, 16'h0000);
        check("async_reset_nzcv", {12'd0, nzcv_f}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check("post_reset_res", {15'd0, res_f}, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_branch_unit.md
Name: cond_branch_unit

Overview:
- Sits directly downstream of zero_flag and the 64-bit ALU in the EX stage.
- Holds the architectural NZCV flag register, written only by flag-setting ops (ADDS/SUBS).
- Resolves B.cond, CBZ and CBNZ using the stored flags, or the live ALU flags when forwarding applies.
- Registers the taken/not-taken decision one cycle later for the fetch/PC-select logic; supports stall and flush.

Parameters:
- FORWARD_EN, 1: when 1, a B.cond in the same cycle as a flag write uses the live ALU flags; when 0, it uses the stored flags.
- RESET_NZCV, 4'b0000: reset value of the flag register, bit order {N,Z,C,V}.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  active-low asynchronous reset.
- alu_zero  input  1  zero output of zero_flag on the ALU result.
- alu_neg  input  1  ALU result bit 63.
- alu_carry  input  1  ALU carry-out.
- alu_ovf  input  1  ALU signed overflow.
- set_flags  input  1  current EX op writes NZCV.
- op_valid  input  1  EX slot holds a real instruction.
- br_type  input  2  0 NONE, 1 BCOND, 2 CBZ, 3 CBNZ.
- cond  input  4  B.cond condition code.
- reg_zero  input  1  zero flag of the CBZ/CBNZ register operand (second zero_flag instance).
- stall  input  1  freeze the EX stage.
- flush  input  1  kill the EX op and any pending decision.
- nzcv  output  4  stored flags {N,Z,C,V}.
- br_resolved  output  1  registered; a decision is presented this cycle.
- br_taken  output  1  registered; branch taken, meaningful only when br_resolved=1.

Behaviour:
- Reset, asynchronous, while reset=0: nzcv=RESET_NZCV, br_resolved=0, br_taken=0, FSM=IDLE. Reset asserted mid-operation drops any pending decision immediately, with no partial output.
- Define accept = op_valid & !stall & !flush.
- Flag write: on clk, if accept & set_flags, then nzcv <= {alu_neg, alu_zero, alu_carry, alu_ovf}. Otherwise nzcv holds. No other path writes nzcv.
- Effective flags eff: if FORWARD_EN & set_flags & op_valid, eff = live ALU flags; else eff = nzcv.
- Condition evaluation (combinational, on eff), codes 0-15:
  - EQ: Z. NE: !Z. HS: C. LO: !C.
  - MI: N. PL: !N. VS: V. VC: !V.
  - HI: C & !Z. LS: !C | Z. GE: N==V. LT: N!=V.
  - GT: !Z & N==V. LE: Z | N!=V. 14 and 15: always true.
- Branch outcome: CBZ taken = reg_zero; CBNZ taken = !reg_zero. CBZ/CBNZ never read and never write flags.
- FSM with two states, IDLE and RESOLVE:
  - IDLE -> RESOLVE on accept & br_type!=NONE; the computed taken value is latched.
  - RESOLVE: br_resolved=1 and br_taken=latched value for exactly one cycle.
  - RESOLVE -> RESOLVE if a new branch is accepted the same cycle (back-to-back branches).
  - RESOLVE -> IDLE otherwise.
  - Latency: decision visible exactly 1 cycle after acceptance.
- Flush: any cycle with flush=1 drops the EX op (no flag write, no acceptance). The next cycle has br_resolved=0, including while in RESOLVE. flush takes priority over stall.
- Stall: with stall=1 and flush=0, nzcv holds. An already-presented RESOLVE output completes its single cycle; there is no re-issue.
- Outputs outside RESOLVE: br_resolved=0, br_taken=0.
- Ops with op_valid=0 are ignored entirely.

Decomposition:
- Package cond_pkg holds:
  - br_type_t enum (NONE, BCOND, CBZ, CBNZ).
  - cond_t 4-bit codes EQ..NV.
  - NZCV bit-index constants N_IDX=3, Z_IDX=2, C_IDX=1, V_IDX=0.
- Sub-module cond_eval: purely combinational, inputs (cond, eff flags), output taken.
- The flag register and FSM stay in the top module.

Test Plan:
- Reset then release with no ops: nzcv=0000, br_resolved=0 for 5 cycles. Assert reset mid-RESOLVE: outputs 0 immediately, before the next clk edge.
- SUBS with alu_zero=1, alu_carry=1, set_flags=1: next cycle nzcv=0110. Then B.cond EQ (0000): one cycle later br_resolved=1, br_taken=1. B.cond LO (0011): br_taken=0.
- Forwarding: same cycle set_flags=1, alu_neg=1, alu_ovf=0, br_type=BCOND, cond=LT (1011), with stored nzcv=0000. FORWARD_EN=1 gives br_taken=1; FORWARD_EN=0 gives br_taken=0.
- CBZ with reg_zero=1 -> br_taken=1. CBNZ with reg_zero=1 -> br_taken=0. nzcv unchanged in both cases.
- Flush: BCOND AL (1110) with flush=1 -> br_resolved stays 0. SUBS with flush=1 -> nzcv unchanged.
- Stall: SUBS with stall=1 -> nzcv unchanged; release stall -> flags written next edge. Two back-to-back BCOND (EQ then NE, Z=1) -> br_resolved high 2 consecutive cycles, br_taken 1 then 0.
